fetch_issue: RTL and testbench
==============================

Name: fetch_issue

Overview:
- Instruction fetch and issue unit that produces the 4-bit opcode stream consumed by the pipeline's opcode-to-control decoder.
- Drives a synchronous instruction memory and holds its PC.
- Handles stalls with a 2-entry skid buffer, redirects on JMP itself, and accepts BEQ redirects from execute.
- Every empty issue slot is presented as NOP (opcode 0000), so the decoder needs no valid qualifier.

Parameters:
- PC_W, 8, program counter and instruction-address width.
- INSTR_W, 16, instruction width; [15:12] is the opcode, [11:0] is the operand field.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- imem_addr  out  PC_W  fetch address; read data returns the next cycle.
- imem_rdata  in  INSTR_W  instruction for the address presented on the previous cycle.
- stall  in  1  downstream cannot accept; hold the current issue slot.
- br_taken  in  1  BEQ resolved taken in execute; pulses for one cycle.
- br_target  in  PC_W  BEQ target, valid with br_taken.
- opcode  out  4  issued opcode; 0000 (NOP) when issue_valid=0.
- operand  out  12  issued operand field; 0 when issue_valid=0.
- issue_valid  out  1  the current slot holds a real instruction.
- issue_pc  out  PC_W  PC of the issued instruction; 0 when invalid.

Behaviour:
- Reset (while rst=1 and on the cycle after):
  - PC=RESET_PC, state=BOOT, skid buffer empty.
  - issue_valid=0, opcode=0000, operand=0, issue_pc=0, imem_addr=RESET_PC.
  - Reset mid-operation discards all in-flight fetches and all skid entries.
- Opcode classes are package constants:
  - 0000 NOP; 0001-0111 ALU.
  - 1001 LD, 1010 ST, 1100 RES.
  - 1011 BEQ, 1111 JMP.
- FSM states:
  - BOOT: one cycle while the first read is in flight. Go to RUN and advance PC by 1.
  - RUN: each cycle the returned word enters the skid buffer (capacity 2) if its fetch is not squashed. The head issues when stall=0.
  - REDIRECT: one cycle. The in-flight fetch is squashed, PC is set to the target, then go to RUN.
- PC advance:
  - Increment modulo 2^PC_W (wraps from 255 to 0) only when the skid buffer will hold at most 1 entry after this cycle.
  - Otherwise hold PC and re-present the same imem_addr.
- Issue latency: an instruction fetched at cycle t is issued at t+1 at the earliest.
- Stall:
  - Outputs hold bit-exact while stall=1.
  - The skid buffer absorbs the one already in-flight word; no instruction is lost or duplicated.
- JMP:
  - On issuing JMP (not stalled), target = operand[PC_W-1:0].
  - Enter REDIRECT and squash the sequential word behind the JMP.
  - The JMP itself is issued, so the decoder sees 1111.
  - Penalty: 1 NOP slot.
- BEQ:
  - Issued like any other instruction.
  - On br_taken: flush the skid buffer and the in-flight fetch, force the next slot to NOP, load PC=br_target, enter REDIRECT.
  - br_taken overrides stall for the flush: issue_valid drops to 0 the following cycle.
- Simultaneous events:
  - br_taken and issue of JMP in the same cycle: br_taken wins and the JMP is discarded (not counted as issued).
  - rst overrides everything.
- Full/empty:
  - Skid empty and stall=0: issue_valid=0 (NOP bubble).
  - Skid full: PC holds and no new fetch is accepted.

Decomposition:
- Package isa_pkg: opcode localparams (OP_NOP, OP_LD, OP_ST, OP_BEQ, OP_RES, OP_JMP), field slices OPC_HI/OPC_LO, and the FSM state encoding (BOOT, RUN, REDIRECT). The decoder reuses the same package.
- One sub-module: issue_skid, a 2-entry FIFO of {pc, instruction} with push, pop, flush, full and empty.

Test Plan:
- Reset, then imem holds 0x1001, 0x2002, 0x0000 at addresses 0-2 -> opcode sequence 0001, 0010, 0000 with issue_pc 0, 1, 2. First valid slot is 2 cycles after rst deasserts.
- stall=1 for 3 cycles mid-stream -> outputs frozen. After release the sequence resumes with no gap, no skip and no duplicate. imem_addr held while the skid buffer is full.
- Address 4 holds JMP 0xF020 -> 1111 issued at issue_pc 4, then one NOP slot, then the instruction at address 0x20. Address 5 is never issued.
- BEQ at address 6, br_taken pulsed 2 cycles later with br_target=0x40 -> slots fetched from 7 and 8 become NOP, next valid issue_pc=0x40.
- PC at 0xFF with sequential code -> next issue_pc 0x00 (wrap).
- rst asserted while stall=1 and skid full -> next cycle: issue_valid=0, opcode=0000, imem_addr=RESET_PC. No stale instruction issues afterwards.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA constants: opcode classes, instruction field slices and fetch FSM encoding.
// Imported by the fetch/issue unit and by the opcode-to-control decoder.
package isa_pkg;

  localparam int unsigned OPC_HI = 15;
  localparam int unsigned OPC_LO = 12;
  localparam int unsigned OPC_W  = 4;
  localparam int unsigned OPD_W  = 12;

  localparam logic [OPC_W-1:0] OP_NOP = 4'b0000;
  localparam logic [OPC_W-1:0] OP_LD  = 4'b1001;
  localparam logic [OPC_W-1:0] OP_ST  = 4'b1010;
  localparam logic [OPC_W-1:0] OP_BEQ = 4'b1011;
  localparam logic [OPC_W-1:0] OP_RES = 4'b1100;
  localparam logic [OPC_W-1:0] OP_JMP = 4'b1111;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/issue_skid.sv
// Two-entry FIFO of {pc, instruction} absorbing in-flight fetches while issue is stalled.
// Flush dominates push/pop so a redirect can never leave a stale entry behind.
module issue_skid #(
  parameter int unsigned W = 24
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout_c,
  output logic         o_full_c,
  output logic         o_empty_c
);

  logic [W-1:0] r_mem [2];
  logic         r_wr;
  logic         r_rd;
  logic [1:0]   r_count;

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (i_rst || i_flush) begin
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) r_wr <= ~r_wr;
      if (i_pop)  r_rd <= ~r_rd;
      r_count <= r_count + 2'(i_push) - 2'(i_pop);
    end
  end

  assign o_dout_c  = r_mem[r_rd];
  assign o_full_c  = (r_count == 2'd2);
  assign o_empty_c = (r_count == 2'd0);

endmodule

// File: rtl/fetch_issue.sv
// Instruction fetch and issue: drives the synchronous imem, buffers stalled fetches,
// redirects on JMP/BEQ and presents empty issue slots as NOP.
module fetch_issue
  import isa_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter int unsigned     INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  output logic [OPC_W-1:0]   opcode,
  output logic [OPD_W-1:0]   operand,
  output logic               issue_valid,
  output logic [PC_W-1:0]    issue_pc
);

  localparam int unsigned ENT_W = PC_W + INSTR_W;

  fetch_state_e       r_state, w_state_n;
  logic [PC_W-1:0]    r_pc, w_pc_n;
  logic               r_fv, w_fv_n;
  logic [PC_W-1:0]    r_fpc, w_fpc_n;

  logic               r_valid, w_slot_valid;
  logic [OPC_W-1:0]   r_opc, w_slot_opc;
  logic [OPD_W-1:0]   r_opd, w_slot_opd;
  logic [PC_W-1:0]    r_ipc, w_slot_pc;

  logic [ENT_W-1:0]   w_head;
  logic               w_full, w_empty, w_push, w_pop, w_flush;
  logic               w_load, w_jmp, w_two_next;
  logic               w_cand_valid;
  logic [PC_W-1:0]    w_cand_pc;
  logic [INSTR_W-1:0] w_cand_instr;

  issue_skid #(.W(ENT_W)) u_skid (
    .clk       (clk),
    .i_rst     (rst),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_flush   (w_flush),
    .i_din     ({r_fpc, imem_rdata}),
    .o_dout_c  (w_head),
    .o_full_c  (w_full),
    .o_empty_c (w_empty)
  );

  // Next issue candidate: skid head first (program order), else the returning word.
  always_comb begin
    w_load       = !stall;
    w_pop        = 1'b0;
    w_cand_valid = r_fv;
    w_cand_pc    = r_fpc;
    w_cand_instr = imem_rdata;
    if (!w_empty) begin
      w_cand_valid = 1'b1;
      w_cand_pc    = w_head[ENT_W-1:INSTR_W];
      w_cand_instr = w_head[INSTR_W-1:0];
      w_pop        = w_load;
    end
    w_jmp      = w_load && w_cand_valid && (w_cand_instr[OPC_HI:OPC_LO] == OP_JMP);
    w_flush    = br_taken || w_jmp;
    w_push     = r_fv && !(w_load && w_empty) && !w_flush;
    w_two_next = (w_full && !w_pop) || (!w_full && !w_empty && w_push && !w_pop);
  end

  // Fetch FSM; a fetch is accepted only when its word is guaranteed skid space.
  always_comb begin
    w_state_n = r_state;
    w_pc_n    = r_pc;
    w_fv_n    = 1'b0;
    w_fpc_n   = r_fpc;
    if (br_taken) begin
      w_state_n = REDIRECT;
      w_pc_n    = br_target;
    end else if (w_jmp) begin
      w_state_n = REDIRECT;
      w_pc_n    = w_cand_instr[PC_W-1:0];
    end else begin
      case (r_state)
        BOOT, REDIRECT: begin
          w_state_n = RUN;
          w_fv_n    = 1'b1;
          w_fpc_n   = r_pc;
          w_pc_n    = r_pc + PC_W'(1);
        end
        RUN: begin
          if (!w_two_next) begin
            w_fv_n  = 1'b1;
            w_fpc_n = r_pc;
            w_pc_n  = r_pc + PC_W'(1);
          end
        end
        default: w_state_n = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
      r_fv    <= 1'b0;
      r_fpc   <= RESET_PC;
    end else begin
      r_state <= w_state_n;
      r_pc    <= w_pc_n;
      r_fv    <= w_fv_n;
      r_fpc   <= w_fpc_n;
    end
  end

  // Issue slot: a taken branch forces NOP even while stalled.
  always_comb begin
    w_slot_valid = r_valid;
    w_slot_opc   = r_opc;
    w_slot_opd   = r_opd;
    w_slot_pc    = r_ipc;
    if (br_taken) begin
      w_slot_valid = 1'b0;
      w_slot_opc   = OP_NOP;
      w_slot_opd   = '0;
      w_slot_pc    = '0;
    end else if (w_load) begin
      w_slot_valid = w_cand_valid;
      w_slot_opc   = w_cand_valid ? w_cand_instr[OPC_HI:OPC_LO] : OP_NOP;
      w_slot_opd   = w_cand_valid ? w_cand_instr[OPD_W-1:0] : '0;
      w_slot_pc    = w_cand_valid ? w_cand_pc : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_opc   <= OP_NOP;
      r_opd   <= '0;
      r_ipc   <= '0;
    end else begin
      r_valid <= w_slot_valid;
      r_opc   <= w_slot_opc;
      r_opd   <= w_slot_opd;
      r_ipc   <= w_slot_pc;
    end
  end

  assign imem_addr   = r_pc;
  assign issue_valid = r_valid;
  assign opcode      = r_opc;
  assign operand     = r_opd;
  assign issue_pc    = r_ipc;

endmodule

// File: tb/tb_fetch_issue.sv
// Directed bench for fetch_issue: sequential issue, stall/skid, JMP, BEQ flush, PC wrap, reset.
// Slot values are packed as {issue_valid, opcode, operand, issue_pc}.
module tb_fetch_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [7:0]  br_target;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [3:0]  opcode;
  logic [11:0] operand;
  logic        issue_valid;
  logic [7:0]  issue_pc;

  logic [15:0] mem [256];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= mem[imem_addr];

  fetch_issue #(.PC_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .opcode      (opcode),
    .operand     (operand),
    .issue_valid (issue_valid),
    .issue_pc    (issue_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 8'h00;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({issue_valid, opcode, operand, issue_pc} !== 25'h0) begin
        errors++;
        $display("FAIL reset slot %0d: got %h expected %h", i, {issue_valid, opcode, operand, issue_pc}, 25'h0);
      end
      checks++;
      if (imem_addr !== 8'h00) begin
        errors++;
        $display("FAIL reset imem_addr %0d: got %h expected 00", i, imem_addr);
      end
    end
  endtask

  task automatic test_sequential();
    logic [24:0] exp [5] = '{25'h0, {1'b1, 16'h1001, 8'h00}, {1'b1, 16'h2002, 8'h01},
                             {1'b1, 16'h0000, 8'h02}, {1'b1, 16'h3003, 8'h03}};
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({issue_valid, opcode, operand, issue_pc} !== exp[i]) begin
        errors++;
        $display("FAIL seq slot %0d: got %h expected %h", i, {issue_valid, opcode, operand, issue_pc}, exp[i]);
      end
      if (i == 0) begin
        checks++;
        if (imem_addr !== 8'h01) begin
          errors++;
          $display("FAIL boot imem_addr: got %h expected 01", imem_addr);
        end
      end
    end
  endtask

  task automatic test_jmp();
    logic [24:0] exp [3] = '{{1'b1, 16'hF020, 8'h04}, 25'h0, {1'b1, 16'h5020, 8'h20}};
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({issue_valid, opcode, operand, issue_pc} !== exp[i]) begin
        errors++;
        $display("FAIL jmp slot %0d: got %h expected %h", i, {issue_valid, opcode, operand, issue_pc}, exp[i]);
      end
      if (i == 0) begin
        checks++;
        if (imem_addr !== 8'h20) begin
          errors++;
          $display("FAIL jmp imem_addr: got %h expected 20", imem_addr);
        end
      end
    end
  endtask

  // br_taken arrives (with stall held) while the BEQ at 0x06 sits in the issue slot.
  task automatic test_beq();
    logic [24:0] exp [7] = '{{1'b1, 16'h6021, 8'h21}, {1'b1, 16'hF006, 8'h22}, 25'h0,
                             {1'b1, 16'hB123, 8'h06}, 25'h0, 25'h0, {1'b1, 16'h2040, 8'h40}};
    for (int i = 0; i < 7; i++) begin
      if (i == 4) begin
        br_taken = 1'b1; br_target = 8'h40; stall = 1'b1;
      end
      tick();
      br_taken = 1'b0; stall = 1'b0;
      checks++;
      if ({issue_valid, opcode, operand, issue_pc} !== exp[i]) begin
        errors++;
        $display("FAIL beq slot %0d: got %h expected %h", i, {issue_valid, opcode, operand, issue_pc}, exp[i]);
      end
      if (i == 4) begin
        checks++;
        if (imem_addr !== 8'h40) begin
          errors++;
          $display("FAIL beq imem_addr: got %h expected 40", imem_addr);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [24:0] exp [6] = '{{1'b1, 16'h3041, 8'h41}, {1'b1, 16'hF0FE, 8'h42}, 25'h0,
                             {1'b1, 16'h40FE, 8'hFE}, {1'b1, 16'h50FF, 8'hFF}, {1'b1, 16'h1001, 8'h00}};
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({issue_valid, opcode, operand, issue_pc} !== exp[i]) begin
        errors++;
        $display("FAIL wrap slot %0d: got %h expected %h", i, {issue_valid, opcode, operand, issue_pc}, exp[i]);
      end
      if (i == 3) begin
        checks++;
        if (imem_addr !== 8'h00) begin
          errors++;
          $display("FAIL wrap imem_addr: got %h expected 00", imem_addr);
        end
      end
    end
  endtask

  // Three stalled cycles fill the skid; release must resume with no gap and JMP pops from the skid.
  task automatic test_stall();
    logic [24:0] exp [11] = '{25'h0, {1'b1, 16'h1001, 8'h00},
                              {1'b1, 16'h1001, 8'h00}, {1'b1, 16'h1001, 8'h00}, {1'b1, 16'h1001, 8'h00},
                              {1'b1, 16'h2002, 8'h01}, {1'b1, 16'h0000, 8'h02}, {1'b1, 16'h3003, 8'h03},
                              {1'b1, 16'hF020, 8'h04}, 25'h0, {1'b1, 16'h5020, 8'h20}};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      stall = (i >= 2 && i <= 4);
      tick();
      checks++;
      if ({issue_valid, opcode, operand, issue_pc} !== exp[i]) begin
        errors++;
        $display("FAIL stall slot %0d: got %h expected %h", i, {issue_valid, opcode, operand, issue_pc}, exp[i]);
      end
      if (i >= 2 && i <= 4) begin
        checks++;
        if (imem_addr !== 8'h03) begin
          errors++;
          $display("FAIL stall imem_addr %0d: got %h expected 03", i, imem_addr);
        end
      end
    end
    stall = 1'b0;
  endtask

  task automatic test_reset_full();
    logic [24:0] exp [3] = '{25'h0, {1'b1, 16'h1001, 8'h00}, {1'b1, 16'h2002, 8'h01}};
    do_reset();
    tick();
    tick();
    stall = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({issue_valid, opcode, operand, issue_pc} !== 25'h0) begin
      errors++;
      $display("FAIL rst_full slot: got %h expected %h", {issue_valid, opcode, operand, issue_pc}, 25'h0);
    end
    checks++;
    if (imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL rst_full imem_addr: got %h expected 00", imem_addr);
    end
    rst = 1'b0; stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({issue_valid, opcode, operand, issue_pc} !== exp[i]) begin
        errors++;
        $display("FAIL rst_full resume %0d: got %h expected %h", i, {issue_valid, opcode, operand, issue_pc}, exp[i]);
      end
    end
  endtask

  // br_taken in the same cycle the JMP at 0x04 would issue: branch wins, JMP discarded.
  task automatic test_br_vs_jmp();
    logic [24:0] exp [3] = '{25'h0, 25'h0, {1'b1, 16'h7080, 8'h80}};
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if ({issue_valid, opcode, operand, issue_pc} !== {1'b1, 16'h3003, 8'h03}) begin
      errors++;
      $display("FAIL brjmp setup: got %h expected %h", {issue_valid, opcode, operand, issue_pc}, {1'b1, 16'h3003, 8'h03});
    end
    br_taken = 1'b1; br_target = 8'h80;
    for (int i = 0; i < 3; i++) begin
      tick();
      br_taken = 1'b0;
      checks++;
      if ({issue_valid, opcode, operand, issue_pc} !== exp[i]) begin
        errors++;
        $display("FAIL brjmp slot %0d: got %h expected %h", i, {issue_valid, opcode, operand, issue_pc}, exp[i]);
      end
      if (i == 0) begin
        checks++;
        if (imem_addr !== 8'h80) begin
          errors++;
          $display("FAIL brjmp imem_addr: got %h expected 80", imem_addr);
        end
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 16'h7000 | 16'(a);
    mem[8'h00] = 16'h1001; mem[8'h01] = 16'h2002; mem[8'h02] = 16'h0000;
    mem[8'h03] = 16'h3003; mem[8'h04] = 16'hF020; mem[8'h05] = 16'h6005;
    mem[8'h06] = 16'hB123; mem[8'h07] = 16'h7007; mem[8'h08] = 16'h1008;
    mem[8'h20] = 16'h5020; mem[8'h21] = 16'h6021; mem[8'h22] = 16'hF006;
    mem[8'h40] = 16'h2040; mem[8'h41] = 16'h3041; mem[8'h42] = 16'hF0FE;
    mem[8'hFE] = 16'h40FE; mem[8'hFF] = 16'h50FF;

    test_reset();
    test_sequential();
    test_jmp();
    test_beq();
    test_wrap();
    test_stall();
    test_reset_full();
    test_br_vs_jmp();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
